mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, max wait cycles for mem_ready before an access aborts (range 1..15).
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  EXMEM stage holds a valid instruction.
REQ-005 mem_to_reg  in  1  load (LW) request.
REQ-006 reg_to_mem  in  1  store (SW) request.
REQ-007 reg_write  in  1  instruction writes regfile.
REQ-008 reg_rd  in  4  destination register.
REQ-009 alu_result  in  16  ALU result / memory address.
REQ-010 store_data  in  16  data for SW.
REQ-011 mem_req  out  1  data-memory request, registered.
REQ-012 mem_we  out  1  1 = write, 0 = read, registered.
REQ-013 mem_addr  out  16  memory address, registered.
REQ-014 mem_wdata  out  16  memory write data, registered.
REQ-015 mem_ready  in  1  memory completes the access this cycle.
REQ-016 mem_rdata  in  16  read data, valid when mem_ready=1.
REQ-017 mem_stall  out  1  combinational; upstream stages freeze and hold all inputs stable while 1.
REQ-018 wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  registered MEMWB controls.
REQ-019 wb_reg_rd  out  4; wb_data  out  16  registered MEMWB payload.
REQ-020 mem_err  out  1  sticky timeout flag.

Function
REQ-021 memop = in_valid & (mem_to_reg | reg_to_mem); mem_to_reg and reg_to_mem both set is illegal; mem_to_reg has priority.
REQ-022 FSM states IDLE, ACCESS; reset state IDLE.
REQ-023 IDLE & memop -> ACCESS next edge; mem_req=1, mem_we=reg_to_mem&~mem_to_reg, mem_addr=alu_result, mem_wdata=store_data, wait counter=0.
REQ-024 IDLE & ~memop: next edge wb_valid=in_valid, wb_data=alu_result, wb_reg_rd=reg_rd, wb_reg_write=reg_write&in_valid, wb_mem_to_reg=0; latency 1 cycle.
REQ-025 mem_stall = memop & ~(state==ACCESS & mem_ready); 0 whenever in_valid=0.
REQ-026 ACCESS & mem_ready -> IDLE next edge; mem_req=0; wb_valid=1, wb_reg_rd=reg_rd, wb_reg_write=reg_write&~mem_we, wb_mem_to_reg=~mem_we, wb_data=mem_rdata for load, alu_result for store.
REQ-027 ACCESS & ~mem_ready: counter +1 per cycle, mem_req/mem_we/mem_addr/mem_wdata held constant, wb_valid=0 (bubble).
REQ-028 Counter == TIMEOUT-1 & ~mem_ready: next edge mem_err=1 (sticky), mem_req=0, wb_valid=0, state IDLE, and mem_stall=0 in that cycle so the faulting instruction retires as a bubble.
REQ-029 mem_ready in IDLE is ignored.
REQ-030 Back-to-back memops: load completes (IDLE), next memop starts on following edge; minimum memop latency 2 cycles (issue + ready).
REQ-031 wb_* outputs change only on clock edges; one wb_valid pulse per retired instruction, none for aborted ones.

Reset
REQ-032 rst=1 immediately forces state IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all wb_*=0, mem_err=0.
REQ-033 rst during ACCESS abandons the access; no wb_valid is produced for it; late mem_ready after reset is ignored.

Verification
REQ-034 ALU op: in_valid=1, reg_write=1, reg_rd=3, alu_result=0x1234 -> next edge wb_valid=1, wb_data=0x1234, wb_reg_rd=3, mem_stall=0.
REQ-035 Load: mem_to_reg=1, alu_result=0x0040, mem_ready after 3 cycles with rdata=0xBEEF -> mem_req=1/addr 0x0040/we=0, stall high 3 cycles, then wb_data=0xBEEF, wb_mem_to_reg=1.
REQ-036 Store: reg_to_mem=1, addr 0x0010, store_data=0x00AA, ready 1 cycle after req -> mem_we=1, wdata=0x00AA, wb_valid=1, wb_reg_write=0.
REQ-037 Timeout: load, mem_ready held 0 -> after TIMEOUT cycles mem_err=1, mem_req=0, no wb_valid, stall released; mem_err stays 1 until rst.
REQ-038 rst asserted mid-ACCESS then mem_ready pulsed -> all outputs 0 immediately, no wb_valid, state IDLE.
REQ-039 Back-to-back load then ALU op -> load wb_valid then ALU wb_valid on consecutive edges, no lost or duplicated pulse.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: issues data-memory accesses for loads/stores,
// stalls upstream until the memory answers or times out, and drives MEMWB.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_to_reg,
  input  logic        reg_to_mem,
  input  logic        reg_write,
  input  logic [3:0]  reg_rd,
  input  logic [15:0] alu_result,
  input  logic [15:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [3:0]  wb_reg_rd,
  output logic [15:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [3:0]  wb_reg_rd_q, wb_reg_rd_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        mem_err_q, mem_err_d;

  logic        memop_s;
  logic        done_s;
  logic        timeout_s;

  // Stall decode; the timeout cycle drops the stall so the faulting op leaves as a bubble.
  always_comb begin
    memop_s   = in_valid & (mem_to_reg | reg_to_mem);
    done_s    = (state_q == ACCESS) & mem_ready;
    timeout_s = (state_q == ACCESS) & ~mem_ready & (cnt_q == CNT_LAST);
    mem_stall = memop_s & ~done_s & ~timeout_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    wb_valid_d      = wb_valid_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_reg_rd_d     = wb_reg_rd_q;
    wb_data_d       = wb_data_q;
    mem_err_d       = mem_err_q;
    case (state_q)
      IDLE: begin
        if (memop_s) begin
          state_d     = ACCESS;
          cnt_d       = 4'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = reg_to_mem & ~mem_to_reg;
          mem_addr_d  = alu_result;
          mem_wdata_d = store_data;
          wb_valid_d  = 1'b0;
        end else begin
          wb_valid_d      = in_valid;
          wb_data_d       = alu_result;
          wb_reg_rd_d     = reg_rd;
          wb_reg_write_d  = reg_write & in_valid;
          wb_mem_to_reg_d = 1'b0;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d         = IDLE;
          cnt_d           = 4'd0;
          mem_req_d       = 1'b0;
          wb_valid_d      = 1'b1;
          wb_reg_rd_d     = reg_rd;
          wb_reg_write_d  = reg_write & ~mem_we_q;
          wb_mem_to_reg_d = ~mem_we_q;
          wb_data_d       = mem_we_q ? alu_result : mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = 4'd0;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b0;
          mem_err_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q + 4'd1;
          wb_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = 4'd0;
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 16'd0;
      mem_wdata_q     <= 16'd0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_reg_rd_q     <= 4'd0;
      wb_data_q       <= 16'd0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_reg_rd_q     <= wb_reg_rd_d;
      wb_data_q       <= wb_data_d;
      mem_err_q       <= mem_err_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_reg_rd     = wb_reg_rd_q;
  assign wb_data       = wb_data_q;
  assign mem_err       = mem_err_q;

endmodule
